// File: rtl/test_pattern_app_pkg.sv
// Shared definitions for the test-pattern generator: FSM states, pattern
// mode encodings and the MMIO control-word field positions.
package test_pattern_app_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_GRAD  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  localparam int TAP_EN       = 31;
  localparam int TAP_ANIM     = 30;
  localparam int TAP_RGB_MSB  = 25;
  localparam int TAP_RGB_LSB  = 2;
  localparam int TAP_MODE_MSB = 1;
  localparam int TAP_MODE_LSB = 0;

endpackage

// File: rtl/test_pattern_app_if.sv
// Pixel stream towards the DRAM writer: two pixels per 64-bit word,
// valid/ready handshake.
interface test_pattern_app_if;
  logic [63:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pattern_pixel.sv
// Combinational generator for one {8'h00,R,G,B} pixel from its effective
// x position, line, frame count and the latched mode/colour.
module pattern_pixel
  import test_pattern_app_pkg::*;
#(
  parameter int BAR_SHIFT = 7
) (
  input  logic [15:0] x_eff,
  input  logic [15:0] y,
  input  logic [15:0] frame_cnt,
  input  logic [1:0]  mode,
  input  logic [23:0] rgb,
  output logic [31:0] pixel
);

  logic [15:0] bar_sh;
  logic [2:0]  bar;
  logic        unused_bits;

  assign bar_sh      = x_eff >> BAR_SHIFT;
  assign bar         = bar_sh[2:0];
  assign unused_bits = ^{bar_sh[15:3], y[15:8], frame_cnt[15:8]};

  always_comb begin
    pixel = '0;
    case (mode)
      MODE_SOLID: pixel[23:0] = rgb;
      MODE_BARS:  pixel[23:0] = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      MODE_GRAD:  pixel[23:0] = {x_eff[7:0], y[7:0], frame_cnt[7:0]};
      default:    pixel[23:0] = (x_eff[4] ^ y[4]) ? 24'hFF_FFFF : 24'h00_0000;
    endcase
  end

endmodule

// File: rtl/test_pattern_app.sv
// Raster test-pattern source: emits H_PIX*V_PIX/2 two-pixel words per frame
// over a valid/ready stream, with tear-free control latched at word (0,0).
module test_pattern_app
  import test_pattern_app_pkg::*;
#(
  parameter int H_PIX     = 640,
  parameter int V_PIX     = 480,
  parameter int BAR_SHIFT = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         tap,
  test_pattern_app_if.master  px,
  output logic                frame_done,
  output logic [15:0]         frame_cnt
);

  localparam logic [15:0] X_LAST = 16'(H_PIX - 2);
  localparam logic [15:0] Y_LAST = 16'(V_PIX - 1);

  state_t      state, state_nxt;
  logic [15:0] x_p0, y_p0, x_nxt, y_nxt, fc_nxt, f_off;
  logic [15:0] x_eff0, x_eff1;
  logic [30:0] shadow_p0, shadow_nxt;
  logic [63:0] word_p0, word_nxt;
  logic        vld_p0, vld_nxt, done_nxt;
  logic        xfer, last_word, gen_first, load;

  assign xfer      = vld_p0 & px.ready;
  assign last_word = (x_p0 == X_LAST) && (y_p0 == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Enable is re-evaluated every cycle; a frame in flight always finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (tap[TAP_EN]) state_nxt = RUN;
      RUN, LAST: begin
        if (xfer && last_word) state_nxt = tap[TAP_EN] ? RUN : IDLE;
        else                   state_nxt = tap[TAP_EN] ? RUN : LAST;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gen_first = 1'b0;
    load      = 1'b0;
    vld_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        gen_first = tap[TAP_EN];
        load      = tap[TAP_EN];
        vld_nxt   = tap[TAP_EN];
      end
      RUN, LAST: begin
        done_nxt  = xfer && last_word;
        gen_first = xfer && last_word && tap[TAP_EN];
        load      = xfer && (!last_word || tap[TAP_EN]);
        vld_nxt   = !(xfer && last_word && !tap[TAP_EN]);
      end
      default: ;
    endcase
  end

  always_comb begin
    x_nxt = x_p0;
    y_nxt = y_p0;
    if (xfer) begin
      if (x_p0 == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y_p0 == Y_LAST) ? 16'd0 : y_p0 + 16'd1;
      end else begin
        x_nxt = x_p0 + 16'd2;
      end
    end
  end

  // The word register is loaded from next-cycle position, count and shadow,
  // so word (0,0) of a new frame already sees the incremented frame count.
  assign fc_nxt     = done_nxt ? frame_cnt + 16'd1 : frame_cnt;
  assign shadow_nxt = gen_first ? tap[30:0] : shadow_p0;
  assign f_off      = shadow_nxt[TAP_ANIM] ? fc_nxt : 16'd0;
  assign x_eff0     = x_nxt + f_off;
  assign x_eff1     = x_nxt + 16'd1 + f_off;

  pattern_pixel #(.BAR_SHIFT(BAR_SHIFT)) u_pix_even (
    .x_eff     (x_eff0),
    .y         (y_nxt),
    .frame_cnt (fc_nxt),
    .mode      (shadow_nxt[TAP_MODE_MSB:TAP_MODE_LSB]),
    .rgb       (shadow_nxt[TAP_RGB_MSB:TAP_RGB_LSB]),
    .pixel     (word_nxt[31:0])
  );

  pattern_pixel #(.BAR_SHIFT(BAR_SHIFT)) u_pix_odd (
    .x_eff     (x_eff1),
    .y         (y_nxt),
    .frame_cnt (fc_nxt),
    .mode      (shadow_nxt[TAP_MODE_MSB:TAP_MODE_LSB]),
    .rgb       (shadow_nxt[TAP_RGB_MSB:TAP_RGB_LSB]),
    .pixel     (word_nxt[63:32])
  );

  // Output stage: word register holds steady unless a new word is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p0       <= '0;
      y_p0       <= '0;
      frame_cnt  <= '0;
      shadow_p0  <= '0;
      vld_p0     <= 1'b0;
      frame_done <= 1'b0;
      word_p0    <= '0;
    end else begin
      x_p0       <= x_nxt;
      y_p0       <= y_nxt;
      frame_cnt  <= fc_nxt;
      shadow_p0  <= shadow_nxt;
      vld_p0     <= vld_nxt;
      frame_done <= done_nxt;
      if (load) word_p0 <= word_nxt;
    end
  end

  assign px.data  = word_p0;
  assign px.valid = vld_p0;

endmodule

// File: tb/tb_test_pattern_app.sv
// Directed bench for test_pattern_app: a vector table of (tap, word index,
// expected word) plus hand-written handshake, enable and reset sequences.
module tb_test_pattern_app;

  localparam logic [31:0] T_SOLID = 32'h8048_D158;
  localparam logic [63:0] W_SOLID = 64'h0012_3456_0012_3456;
  localparam logic [63:0] W_BAR0  = 64'h0000_00FF_0000_0000;

  typedef struct {
    string       name;
    logic [31:0] tap;
    bit          sel;
    int          target;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] tap = '0;
  logic        fd, fd2;
  logic [15:0] fc, fc2;
  int          vectors = 0;
  int          miscompares = 0;

  test_pattern_app_if px ();
  test_pattern_app_if px2 ();
  assign px.ready  = ready;
  assign px2.ready = ready;

  test_pattern_app #(.H_PIX(8), .V_PIX(4), .BAR_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .tap(tap), .px(px), .frame_done(fd), .frame_cnt(fc)
  );

  test_pattern_app #(.H_PIX(32), .V_PIX(1), .BAR_SHIFT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .tap(tap), .px(px2), .frame_done(fd2), .frame_cnt(fc2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] t);
    rst_n = 1'b0;
    ready = 1'b1;
    tap   = t;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] exp_m2(input int k);
    int fr  = k / 16;
    int idx = k % 16;
    int x   = 2 * (idx % 4);
    int y   = idx / 4;
    return {8'h00, 8'(x + 1 + fr), 8'(y), 8'(fr), 8'h00, 8'(x + fr), 8'(y), 8'(fr)};
  endfunction

  // Returns the word offered with the target-th transfer since reset (ready=1).
  task automatic get_word(input bit sel, input int target, output logic [63:0] w, output bit ok);
    int cnt = 0;
    ok = 1'b0;
    w  = '0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (sel ? px2.valid : px.valid) begin
        if (cnt == target) begin
          w  = sel ? px2.data : px.data;
          ok = 1'b1;
        end
        cnt++;
      end
    end
  endtask

  vec_t        vecs[17];
  logic [63:0] w, held;
  bit          ok, hold;
  int          cnt, bubbles, lat;
  bit          started;

  initial begin
    vecs[0]  = '{"m0_w0",       32'h8048_D158, 1'b0, 0,  W_SOLID};
    vecs[1]  = '{"m0_w15",      32'h8048_D158, 1'b0, 15, W_SOLID};
    vecs[2]  = '{"m1_w0",       32'h8000_0001, 1'b0, 0,  W_BAR0};
    vecs[3]  = '{"m1_w1",       32'h8000_0001, 1'b0, 1,  64'h0000_FFFF_0000_FF00};
    vecs[4]  = '{"m1_w2",       32'h8000_0001, 1'b0, 2,  64'h00FF_00FF_00FF_0000};
    vecs[5]  = '{"m1_w3",       32'h8000_0001, 1'b0, 3,  64'h00FF_FFFF_00FF_FF00};
    vecs[6]  = '{"m2_w5",       32'h8000_0002, 1'b0, 5,  64'h0003_0100_0002_0100};
    vecs[7]  = '{"m2_w13",      32'h8000_0002, 1'b0, 13, 64'h0003_0300_0002_0300};
    vecs[8]  = '{"m2_f1w0",     32'h8000_0002, 1'b0, 16, 64'h0001_0001_0000_0001};
    vecs[9]  = '{"m2a_f1w0",    32'hC000_0002, 1'b0, 16, 64'h0002_0001_0001_0001};
    vecs[10] = '{"m2a_f1w6",    32'hC000_0002, 1'b0, 22, 64'h0006_0101_0005_0101};
    vecs[11] = '{"m1a_f1w0",    32'hC000_0001, 1'b0, 16, 64'h0000_FF00_0000_00FF};
    vecs[12] = '{"m1a_f2w3",    32'hC000_0001, 1'b0, 35, W_BAR0};
    vecs[13] = '{"m3_x4",       32'h8000_0003, 1'b0, 2,  64'h0};
    vecs[14] = '{"m3w_x16",     32'h8000_0003, 1'b1, 8,  64'h00FF_FFFF_00FF_FFFF};
    vecs[15] = '{"m3w_x14",     32'h8000_0003, 1'b1, 7,  64'h0};
    vecs[16] = '{"m3wa_f1x14",  32'hC000_0003, 1'b1, 23, 64'h00FF_FFFF_0000_0000};

    // Reset state, with enable already requested.
    tap = T_SOLID;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(px.valid), 64'd0);
    check("rst_data", px.data, 64'd0);
    check("rst_frame_done", 64'(fd), 64'd0);
    check("rst_frame_cnt", 64'(fc), 64'd0);
    check("rst_frame_cnt_w", 64'(fc2), 64'd0);

    foreach (vecs[i]) begin
      do_reset(vecs[i].tap);
      get_word(vecs[i].sel, vecs[i].target, w, ok);
      check({vecs[i].name, "_seen"}, 64'(ok), 64'd1);
      check(vecs[i].name, w, vecs[i].exp);
    end

    // Solid frame: 16 words, frame_done with the last, next word without a bubble.
    do_reset(T_SOLID);
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 16; c++) begin
      @(negedge clk);
      if (px.valid) begin
        check("a_word", px.data, W_SOLID);
        check("a_fd_low", 64'(fd), 64'd0);
        cnt++;
      end
    end
    check("a_count", 64'(cnt), 64'd16);
    @(negedge clk);
    check("a_fd_pulse", 64'(fd), 64'd1);
    check("a_frame_cnt", 64'(fc), 64'd1);
    check("a_no_bubble", 64'(px.valid), 64'd1);
    check("a_next_word", px.data, W_SOLID);
    @(negedge clk);
    check("a_fd_one_cycle", 64'(fd), 64'd0);

    // Backpressure at ~30% ready against the mode-2 animated reference.
    do_reset(32'hC000_0002);
    cnt  = 0;
    hold = 1'b0;
    held = '0;
    for (int c = 0; c < 3000 && cnt < 40; c++) begin
      @(negedge clk);
      ready = ($urandom_range(0, 9) < 3);
      if (hold) begin
        check("bp_hold_valid", 64'(px.valid), 64'd1);
        check("bp_hold_data", px.data, held);
        hold = 1'b0;
      end
      if (px.valid && ready) begin
        check("bp_word", px.data, exp_m2(cnt));
        cnt++;
      end else if (px.valid) begin
        hold = 1'b1;
        held = px.data;
      end
    end
    ready = 1'b1;
    check("bp_count", 64'(cnt), 64'd40);

    // Enable dropped at transfer 5 with a mode change: frame finishes unchanged.
    do_reset(T_SOLID);
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 16; c++) begin
      @(negedge clk);
      if (px.valid) begin
        check("c_word", px.data, W_SOLID);
        cnt++;
        if (cnt == 5) tap = 32'h0000_0001;
      end
    end
    check("c_count", 64'(cnt), 64'd16);
    @(negedge clk);
    check("c_valid_drop", 64'(px.valid), 64'd0);
    check("c_frame_cnt", 64'(fc), 64'd1);
    repeat (3) @(negedge clk);
    check("c_stay_idle", 64'(px.valid), 64'd0);
    tap = 32'h8000_0001;
    ok  = 1'b0;
    for (int c = 0; c < 4 && !ok; c++) begin
      @(negedge clk);
      ok = px.valid;
    end
    check("c_restart_seen", 64'(ok), 64'd1);
    check("c_restart_mode", px.data, W_BAR0);

    // Enable dropped then restored mid-frame: continuous stream, new mode at (0,0).
    do_reset(T_SOLID);
    cnt     = 0;
    bubbles = 0;
    started = 1'b0;
    for (int c = 0; c < 100 && cnt < 17; c++) begin
      @(negedge clk);
      if (px.valid) begin
        started = 1'b1;
        check("d_word", px.data, (cnt < 16) ? W_SOLID : W_BAR0);
        cnt++;
        if (cnt == 5) tap = 32'h0000_0001;
        if (cnt == 8) tap = 32'h8000_0001;
      end else if (started) begin
        bubbles++;
      end
    end
    check("d_count", 64'(cnt), 64'd17);
    check("d_bubbles", 64'(bubbles), 64'd0);

    // Reset in the middle of the second frame.
    do_reset(32'hC000_0002);
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 23; c++) begin
      @(negedge clk);
      if (px.valid) cnt++;
    end
    check("r_frame_cnt_pre", 64'(fc), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r_valid_async", 64'(px.valid), 64'd0);
    check("r_data_async", px.data, 64'd0);
    check("r_frame_cnt_async", 64'(fc), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 4 && !ok; c++) begin
      @(negedge clk);
      lat++;
      ok = px.valid;
    end
    check("r_restart_seen", 64'(ok), 64'd1);
    check("r_restart_lat", 64'(lat <= 2), 64'd1);
    check("r_restart_word", px.data, 64'h0001_0000_0000_0000);
    check("r_restart_fc", 64'(fc), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
